// File: rtl/list_builder.sv
// list_builder: write side of the linked-list subsystem.
// Turns an ordered element-pointer stream (lists closed by elem_last) into
// next-pointer link writes (addr -> next, 0 = end), and queues each finished
// list's {head pointer, length} in a small FIFO for the traversal side.
// Optional build macro: LIST_BUILDER_REPEAT_CHECK_EN adds a used-pointer map
// that drops any element already placed in a list since the last reset.
module list_builder #(
    parameter int unsigned N          = 16,
    parameter int unsigned WIDTH      = $clog2(N),
    parameter int unsigned HEAD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] elem_ptr,
    input  logic             elem_last,
    input  logic             elem_vld,
    output logic             elem_rdy,
    output logic             lnk_we,
    output logic [WIDTH-1:0] lnk_wa,
    output logic [WIDTH-1:0] lnk_wd,
    output logic [WIDTH-1:0] head_ptr,
    output logic [WIDTH:0]   head_len,
    output logic             head_vld,
    input  logic             head_rdy,
    output logic             busy,
    output logic             err
);

    localparam int unsigned LEN_W   = WIDTH + 1;
    localparam int unsigned ENTRY_W = WIDTH + LEN_W;
    localparam int unsigned AW      = $clog2(HEAD_DEPTH);
    localparam int unsigned CNT_W   = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MID  = 2'd1,
        TERM = 2'd2
    } state_t;

    // list-building state
    state_t             state_q;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   head_q;
    logic [LEN_W-1:0]   len_q;

    // registered outputs
    logic               lnk_we_q;
    logic [WIDTH-1:0]   lnk_wa_q;
    logic [WIDTH-1:0]   lnk_wd_q;
    logic               busy_q;
    logic               err_q;

    // head/length FIFO
    logic [ENTRY_W-1:0] mem_q [HEAD_DEPTH];
    logic [AW-1:0]      rd_q;
    logic [AW-1:0]      wr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               head_vld_q;
    logic [WIDTH-1:0]   head_ptr_q;
    logic [LEN_W-1:0]   head_len_q;

    // combinational helpers
    logic               accept_c;
    logic               repeat_hit_c;
    logic               drop_c;
    logic               take_c;
    logic               pop_c;
    logic               full_c;
    logic               push_c;
    logic [ENTRY_W-1:0] push_data_c;
    logic [CNT_W-1:0]   cnt_d;
    logic [AW-1:0]      rd_d;
    logic [ENTRY_W-1:0] head_d;

`ifdef LIST_BUILDER_REPEAT_CHECK_EN
    logic [N-1:0]       used_q;
`endif

    assign elem_rdy = (state_q != TERM);
    assign lnk_we   = lnk_we_q;
    assign lnk_wa   = lnk_wa_q;
    assign lnk_wd   = lnk_wd_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign head_vld = head_vld_q;
    assign head_ptr = head_ptr_q;
    assign head_len = head_len_q;

    // Handshake decode, drop detection and FIFO next-state
    always_comb begin
        accept_c     = 1'b0;
        repeat_hit_c = 1'b0;
        drop_c       = 1'b0;
        take_c       = 1'b0;
        pop_c        = 1'b0;
        full_c       = 1'b0;
        push_c       = 1'b0;
        push_data_c  = {head_q, len_q};
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        head_d       = '0;

        accept_c = elem_vld & (state_q != TERM);
`ifdef LIST_BUILDER_REPEAT_CHECK_EN
        repeat_hit_c = used_q[elem_ptr];
`endif
        drop_c = accept_c & ((elem_ptr == '0) | repeat_hit_c);
        take_c = accept_c & ~drop_c;

        pop_c  = head_vld_q & head_rdy;
        full_c = (cnt_q == CNT_W'(HEAD_DEPTH));
        // A pop in the same cycle frees the slot the terminator needs
        push_c = (state_q == TERM) & (~full_c | pop_c);

        cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_d  = pop_c ? (rd_q + AW'(1)) : rd_q;
        // New head comes from the entry being written when it lands in the read slot
        head_d = (push_c && (rd_d == wr_q)) ? push_data_c : mem_q[rd_d];
    end

    // List FSM: link writes, terminator, error pulse and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            head_q   <= '0;
            len_q    <= '0;
            lnk_we_q <= 1'b0;
            lnk_wa_q <= '0;
            lnk_wd_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lnk_we_q <= 1'b0;
            err_q    <= drop_c;
            case (state_q)
                IDLE: begin
                    if (take_c) begin
                        head_q  <= elem_ptr;
                        prev_q  <= elem_ptr;
                        len_q   <= LEN_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= elem_last ? TERM : MID;
                    end
                end
                MID: begin
                    if (take_c) begin
                        lnk_we_q <= 1'b1;
                        lnk_wa_q <= prev_q;
                        lnk_wd_q <= elem_ptr;
                        prev_q   <= elem_ptr;
                        len_q    <= len_q + LEN_W'(1);
                        if (elem_last) begin
                            state_q <= TERM;
                        end
                    end else if (drop_c && elem_last) begin
                        state_q <= TERM;
                    end
                end
                TERM: begin
                    if (push_c) begin
                        lnk_we_q <= 1'b1;
                        lnk_wa_q <= prev_q;
                        lnk_wd_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and registered head entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            head_vld_q <= 1'b0;
            head_ptr_q <= '0;
            head_len_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            head_vld_q <= (cnt_d != '0);
            if (push_c) begin
                wr_q <= wr_q + AW'(1);
            end
            if (cnt_d != '0) begin
                {head_ptr_q, head_len_q} <= head_d;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_q] <= push_data_c;
        end
    end

`ifdef LIST_BUILDER_REPEAT_CHECK_EN
    // Used-pointer map, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used_q <= '0;
        end else if (take_c) begin
            used_q[elem_ptr] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_list_builder.sv
// Scoreboard bench for list_builder: a list-level model queues expected link
// writes and FIFO heads; a negedge monitor compares whatever the DUT presents.
module tb_list_builder;

    localparam int unsigned N  = 16;
    localparam int unsigned W  = 4;
    localparam int unsigned LW = 5;
`ifdef LIST_BUILDER_REPEAT_CHECK_EN
    localparam bit REPCHK = 1'b1;
`else
    localparam bit REPCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  elem_ptr;
    logic          elem_last;
    logic          elem_vld;
    logic          elem_rdy;
    logic          lnk_we;
    logic [W-1:0]  lnk_wa;
    logic [W-1:0]  lnk_wd;
    logic [W-1:0]  head_ptr;
    logic [LW-1:0] head_len;
    logic          head_vld;
    logic          head_rdy;
    logic          busy;
    logic          err;

    list_builder #(.N(N), .WIDTH(W), .HEAD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .elem_ptr(elem_ptr), .elem_last(elem_last), .elem_vld(elem_vld), .elem_rdy(elem_rdy),
        .lnk_we(lnk_we), .lnk_wa(lnk_wa), .lnk_wd(lnk_wd),
        .head_ptr(head_ptr), .head_len(head_len), .head_vld(head_vld), .head_rdy(head_rdy),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [2*W-1:0]  wq [$];
    logic [W+LW-1:0] hq [$];
    logic [W-1:0]    cur [$];
    bit              used [N];
    int              err_exp  = 0;
    int              err_seen = 0;
    int              passed   = 0;
    int              total    = 0;
    bit              rdy_rand = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // close the open list: terminator write and head entry
    task automatic model_close();
        wq.push_back({cur[cur.size()-1], W'(0)});
        hq.push_back({cur[0], LW'(cur.size())});
        cur.delete();
    endtask

    task automatic model_accept(input logic [W-1:0] p, input bit l);
        if (p == '0 || (REPCHK && used[p])) begin
            err_exp++;
            if (l && cur.size() > 0) model_close();
        end else begin
            used[p] = 1'b1;
            if (cur.size() > 0) wq.push_back({cur[cur.size()-1], p});
            cur.push_back(p);
            if (l) model_close();
        end
    endtask

    // monitor: compare link writes and head pops against the scoreboard
    always @(negedge clk) begin
        logic [2*W-1:0]  ew;
        logic [W+LW-1:0] eh;
        if (!rst) begin
            if (lnk_we) begin
                if (wq.size() == 0) begin
                    total++;
                    $display("FAIL link_write: got %0d->%0d expected no write", lnk_wa, lnk_wd);
                end else begin
                    ew = wq.pop_front();
                    check("link_write{wa,wd}", int'({lnk_wa, lnk_wd}), int'(ew));
                end
            end
            if (head_vld && head_rdy) begin
                if (hq.size() == 0) begin
                    total++;
                    $display("FAIL head_pop: got head %0d len %0d expected none", head_ptr, head_len);
                end else begin
                    eh = hq.pop_front();
                    check("head_pop{ptr,len}", int'({head_ptr, head_len}), int'(eh));
                end
            end
            if (err) err_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_rand) head_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] p, input bit l);
        int n = 0;
        elem_ptr  = p;
        elem_last = l;
        elem_vld  = 1'b1;
        forever begin
            @(negedge clk);
            if (elem_rdy) begin
                model_accept(p, l);
                break;
            end
            n++;
            if (n > 200) begin
                total++;
                $display("FAIL send_timeout: got elem_rdy 0 for 200 cycles expected 1");
                break;
            end
            step();
        end
        step();
        elem_vld = 1'b0;
    endtask

    task automatic do_reset();
        elem_vld = 1'b0;
        rst = 1'b1;
        cur.delete();
        wq.delete();
        hq.delete();
        foreach (used[i]) used[i] = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rdy_rand = 1'b0;
        elem_vld = 1'b0;
        head_rdy = 1'b1;
        while ((wq.size() != 0 || hq.size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        repeat (2) step();
        check({tag, "_outstanding"}, wq.size() + hq.size(), 0);
        check({tag, "_idle"}, int'({busy, head_vld}), 0);
        check({tag, "_err_count"}, err_seen, err_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        elem_ptr  = '0;
        elem_last = 1'b0;
        elem_vld  = 1'b0;
        head_rdy  = 1'b0;

        // reset values while rst is high
        @(negedge clk);
        check("rst_lnk", int'({lnk_we, lnk_wa, lnk_wd}), 0);
        check("rst_head", int'({head_vld, head_ptr, head_len}), 0);
        check("rst_busy_err", int'({busy, err}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_elem_rdy", int'(elem_rdy), 1);
        step();

        // 1: three-element list
        head_rdy = 1'b1;
        send(4'd7, 1'b0);
        send(4'd15, 1'b0);
        send(4'd8, 1'b1);
        drain("t1");

        // 2: single-element list, one TERM cycle
        do_reset();
        head_rdy = 1'b1;
        send(4'd6, 1'b1);
        @(negedge clk);
        check("t2_rdy_low_in_term", int'(elem_rdy), 0);
        check("t2_no_write_on_accept", int'(lnk_we), 0);
        @(negedge clk);
        check("t2_rdy_back", int'(elem_rdy), 1);
        check("t2_term_write", int'({lnk_we, lnk_wa, lnk_wd}), int'({1'b1, 4'd6, 4'd0}));
        step();
        drain("t2");

        // 3: FIFO full, fifth list stalls in TERM until a pop
        do_reset();
        head_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) send(W'(i), 1'b1);
        repeat (3) step();
        @(negedge clk);
        check("t3_stuck_rdy", int'(elem_rdy), 0);
        check("t3_stuck_no_write", int'(lnk_we), 0);
        check("t3_stuck_busy_vld", int'({busy, head_vld}), 3);
        step();
        head_rdy = 1'b1;
        step();
        head_rdy = 1'b0;
        @(negedge clk);
        check("t3_release_write", int'({lnk_we, lnk_wa, lnk_wd}), int'({1'b1, 4'd5, 4'd0}));
        check("t3_release_rdy", int'(elem_rdy), 1);
        step();
        drain("t3");

        // 4: null pointer dropped mid-list
        do_reset();
        send(4'd1, 1'b0);
        send(4'd0, 1'b0);
        send(4'd5, 1'b1);
        drain("t4");

        // 5: repeated pointer
        do_reset();
        send(4'd9, 1'b0);
        send(4'd14, 1'b0);
        send(4'd9, 1'b1);
        drain("t5");

        // 6: reset with a list open
        do_reset();
        head_rdy = 1'b1;
        send(4'd2, 1'b0);
        send(4'd4, 1'b0);
        step();
        step();
        check("t6_prefix_written", wq.size(), 0);
        do_reset();
        @(negedge clk);
        check("t6_after_rst", int'({head_vld, busy, lnk_we}), 0);
        step();
        send(4'd3, 1'b1);
        drain("t6");

        // random rounds
        for (int r = 0; r < 8; r++) begin
            do_reset();
            rdy_rand = 1'b1;
            for (int k = 0; k < 25; k++) begin
                send(W'($urandom_range(0, N - 1)), ($urandom_range(0, 3) == 0));
                repeat ($urandom_range(0, 2)) step();
            end
            send(W'($urandom_range(1, N - 1)), 1'b1);
            drain("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
